pbal_match_pipe: RTL and testbench

Parametrised, path-balanced pipelined pattern-match and select unit. It is the sequential successor of our flat match/select decode cones. It handles CHANNELS independent channel fields, each matched against a programmable pattern/care mask. The match is computed in one stage and then carried through a balancing delay line of DEPTH stages with a valid/ready handshake. A two-input kill qualifier travels alongside the data and squashes the result at the output, aligned to the same transaction.

---
 rtl/pbal_match_pipe.sv | 143 ++++++++++++++
 tb/tb_pbal_match_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbal_match_pipe.sv
// Path-balanced pipelined pattern match/select: per-channel masked compare, DEPTH-register delay line, kill squash at output.
// Optional PBAL_PARITY_EN adds per-channel even-parity checking (in_par / out_perr).
module pbal_match_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4,
  localparam int IW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_kill_a,
  input  logic                      in_kill_b,
`ifdef PBAL_PARITY_EN
  input  logic [CHANNELS-1:0]       in_par,
  output logic                      out_perr,
`endif
  input  logic                      cfg_we,
  input  logic [IW-1:0]             cfg_ch,
  input  logic                      cfg_en,
  input  logic [WIDTH-1:0]          cfg_pat,
  input  logic [WIDTH-1:0]          cfg_care,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       out_hit,
  output logic                      out_any,
  output logic [IW-1:0]             out_idx,
  output logic                      out_killed,
  input  logic                      cnt_clr,
  output logic [15:0]               hit_cnt
);

  logic                adv;
  logic [CHANNELS-1:0] en_q;
  logic [WIDTH-1:0]    pat_q  [CHANNELS];
  logic [WIDTH-1:0]    care_q [CHANNELS];
  logic [CHANNELS-1:0] hit0;
  logic                kill0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign kill0    = in_kill_a && in_kill_b;

`ifdef PBAL_PARITY_EN
  logic [CHANNELS-1:0] pmis;
  logic                perr0;
  assign perr0 = |pmis;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    // Out-of-range cfg_ch matches no channel, so such writes fall through.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        en_q[gi]   <= 1'b0;
        pat_q[gi]  <= '0;
        care_q[gi] <= '0;
      end else if (cfg_we && cfg_ch == IW'(gi)) begin
        en_q[gi]   <= cfg_en;
        pat_q[gi]  <= cfg_pat;
        care_q[gi] <= cfg_care;
      end
    end

`ifdef PBAL_PARITY_EN
    assign pmis[gi] = (^in_data[gi*WIDTH +: WIDTH]) ^ in_par[gi];
    assign hit0[gi] = en_q[gi] && !pmis[gi] &&
                      (((in_data[gi*WIDTH +: WIDTH] ^ pat_q[gi]) & care_q[gi]) == '0);
`else
    assign hit0[gi] = en_q[gi] &&
                      (((in_data[gi*WIDTH +: WIDTH] ^ pat_q[gi]) & care_q[gi]) == '0);
`endif
  end

  // Delay line: registers 1..DEPTH-1; the output register is the DEPTH-th.
  logic [DEPTH-1:1]    v_q;
  logic [DEPTH-1:1]    k_q;
  logic [CHANNELS-1:0] h_q [1:DEPTH-1];
`ifdef PBAL_PARITY_EN
  logic [DEPTH-1:1]    p_q;
`endif

  logic [CHANNELS-1:0] hit_next;
  logic [IW-1:0]       idx_next;

  always_comb begin
    hit_next = k_q[DEPTH-1] ? '0 : h_q[DEPTH-1];
    idx_next = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (hit_next[c]) idx_next = IW'(c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q        <= '0;
      k_q        <= '0;
      for (int i = 1; i < DEPTH; i++) h_q[i] <= '0;
      out_valid  <= 1'b0;
      out_hit    <= '0;
      out_any    <= 1'b0;
      out_idx    <= '0;
      out_killed <= 1'b0;
`ifdef PBAL_PARITY_EN
      p_q        <= '0;
      out_perr   <= 1'b0;
`endif
    end else if (adv) begin
      v_q[1] <= in_valid;
      k_q[1] <= kill0;
      h_q[1] <= hit0;
`ifdef PBAL_PARITY_EN
      p_q[1] <= perr0;
`endif
      for (int i = 2; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        k_q[i] <= k_q[i-1];
        h_q[i] <= h_q[i-1];
`ifdef PBAL_PARITY_EN
        p_q[i] <= p_q[i-1];
`endif
      end
      out_valid  <= v_q[DEPTH-1];
      out_hit    <= v_q[DEPTH-1] ? hit_next : '0;
      out_any    <= v_q[DEPTH-1] && (|hit_next);
      out_idx    <= v_q[DEPTH-1] ? idx_next : '0;
      out_killed <= v_q[DEPTH-1] && k_q[DEPTH-1];
`ifdef PBAL_PARITY_EN
      out_perr   <= v_q[DEPTH-1] && p_q[DEPTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      hit_cnt <= '0;
    end else if (out_valid && out_ready && out_any && !out_killed && hit_cnt != 16'hFFFF) begin
      hit_cnt <= hit_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pbal_match_pipe.sv
// Scoreboard bench for pbal_match_pipe: directed vectors push expectations, a negedge monitor pops on output handshakes.
module tb_pbal_match_pipe;
  localparam int WIDTH = 8;
  localparam int CHANNELS = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_kill_a, in_kill_b;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic        cfg_en;
  logic [7:0]  cfg_pat, cfg_care;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_hit;
  logic        out_any;
  logic [1:0]  out_idx;
  logic        out_killed;
  logic        cnt_clr;
  logic [15:0] hit_cnt;
`ifdef PBAL_PARITY_EN
  logic [3:0]  in_par;
  logic        out_perr;
  for (genvar gi = 0; gi < 4; gi++) begin : g_par
    assign in_par[gi] = ^in_data[gi*8 +: 8];
  end
`endif

  always #5 clk = ~clk;

  pbal_match_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_kill_a(in_kill_a), .in_kill_b(in_kill_b),
`ifdef PBAL_PARITY_EN
    .in_par(in_par), .out_perr(out_perr),
`endif
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_pat(cfg_pat), .cfg_care(cfg_care),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit), .out_any(out_any),
    .out_idx(out_idx), .out_killed(out_killed), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
  );

  typedef struct packed {
    logic [3:0] hit;
    logic       any;
    logic [1:0] idx;
    logic       killed;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   popped = 0;

  // Monitor: a handshake completes at the next posedge whenever valid && ready at negedge.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (!rst_n && out_valid) begin
      checks++; failures++;
      $display("FAIL valid_in_reset out_valid=%0b required=0", out_valid);
    end else if (rst_n && out_valid && out_ready) begin
      checks++;
      a = {out_hit, out_any, out_idx, out_killed};
      if (q.size() == 0) begin
        failures++;
        $display("FAIL phantom_output got hit=%b any=%0b idx=%0d killed=%0b required=none", out_hit, out_any, out_idx, out_killed);
      end else begin
        e = q.pop_front();
        popped++;
        if (a !== e) begin
          failures++;
          $display("FAIL txn%0d got hit=%b any=%0b idx=%0d killed=%0b required hit=%b any=%0b idx=%0d killed=%0b",
                   popped, out_hit, out_any, out_idx, out_killed, e.hit, e.any, e.idx, e.killed);
        end else begin
          $display("txn%0d hit=%b any=%0b idx=%0d killed=%0b ok", popped, out_hit, out_any, out_idx, out_killed);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic ka, input logic kb,
                      input logic [3:0] eh, input logic [1:0] eidx, input logic ek);
    bit acc = 0;
    exp_t e;
    in_data = d; in_kill_a = ka; in_kill_b = kb; in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout in_ready=0 required=1");
    end
    e.hit = eh; e.any = |eh; e.idx = eidx; e.killed = ek;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_kill_a = 1'b0; in_kill_b = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic en, input logic [7:0] pat, input logic [7:0] care);
    cfg_we = 1'b1; cfg_ch = ch; cfg_en = en; cfg_pat = pat; cfg_care = care;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid(output bit seen);
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL out_valid_timeout out_valid=0 required=1");
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   phantom;
    bit   seen;
    logic [7:0] snap;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_kill_a = 0; in_kill_b = 0;
    cfg_we = 0; cfg_ch = '0; cfg_en = 0; cfg_pat = '0; cfg_care = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;

    // 1: reset with in_valid held high
    in_valid = 1'b1; in_data = 32'h1234_5678;
    repeat (2) begin
      @(negedge clk);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_hit_cnt", {16'd0, hit_cnt}, 32'd0);
      chk("reset_out_fields", {24'd0, out_hit, out_any, out_idx, out_killed}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; idle();
    phantom = 0;
    repeat (DEPTH + 2) begin
      @(negedge clk);
      if (out_valid) phantom++;
    end
    chk("no_phantom_after_reset", phantom, 0);

    // 2: basic match on ch2 with latency measurement
    cfg(2'd2, 1'b1, 8'hA5, 8'hF0);
    send(32'h00AF_0000, 0, 0, 4'b0100, 2'd2, 0);
    idle();
    lat = 1; seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else begin @(posedge clk); lat++; end
    end
    chk("latency", lat, DEPTH);
    drain();
    chk("hit_cnt_basic", {16'd0, hit_cnt}, 32'd1);

    // 3: kill alignment on back-to-back traffic
    clr_cnt();
    send(32'h00AF_0000, 0, 0, 4'b0100, 2'd2, 0);
    send(32'h00AF_0000, 1, 1, 4'b0000, 2'd0, 1);
    send(32'h00AF_0000, 0, 0, 4'b0100, 2'd2, 0);
    idle();
    drain();
    chk("hit_cnt_kill", {16'd0, hit_cnt}, 32'd2);
    send(32'h00AF_0000, 1, 0, 4'b0100, 2'd2, 0);
    idle();
    drain();
    chk("hit_cnt_kill_a_only", {16'd0, hit_cnt}, 32'd3);

    // 4: backpressure with four in flight
    cfg(2'd0, 1'b1, 8'h12, 8'hFF);
    cfg(2'd3, 1'b1, 8'h80, 8'h80);
    send(32'h8000_0012, 0, 0, 4'b1001, 2'd0, 0);
    send(32'hFFAF_0000, 0, 0, 4'b1100, 2'd2, 0);
    send(32'h0000_0013, 0, 0, 4'b0000, 2'd0, 0);
    send(32'h00A0_0012, 0, 0, 4'b0101, 2'd0, 0);
    idle();
    out_ready = 1'b0;
    wait_out_valid(seen);
    snap = {out_hit, out_any, out_idx, out_killed};
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_outputs_stable", {24'd0, out_hit, out_any, out_idx, out_killed}, {24'd0, snap});
    end
    chk("stall_first_is_txn_a", {24'd0, snap}, {24'd0, 4'b1001, 1'b1, 2'd0, 1'b0});
    out_ready = 1'b1;
    drain();
    chk("hit_cnt_backpressure", {16'd0, hit_cnt}, 32'd6);

    // 5: config write in the accept cycle uses the old values
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_en = 1'b0; cfg_pat = 8'h12; cfg_care = 8'hFF;
    send(32'h0000_0012, 0, 0, 4'b0001, 2'd0, 0);
    cfg_we = 1'b0;
    send(32'h0000_0012, 0, 0, 4'b0000, 2'd0, 0);
    idle();
    drain();
    chk("hit_cnt_cfg_race", {16'd0, hit_cnt}, 32'd7);

    // 6: counter saturation and clear-wins
    clr_cnt();
    chk("hit_cnt_cleared", {16'd0, hit_cnt}, 32'd0);
    for (int i = 0; i < 65534; i++) send(32'h00AF_0000, 0, 0, 4'b0100, 2'd2, 0);
    idle();
    drain();
    chk("hit_cnt_fffe", {16'd0, hit_cnt}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) send(32'h00AF_0000, 0, 0, 4'b0100, 2'd2, 0);
    idle();
    drain();
    chk("hit_cnt_saturate", {16'd0, hit_cnt}, 32'h0000_FFFF);
    send(32'h00AF_0000, 0, 0, 4'b0100, 2'd2, 0);
    idle();
    wait_out_valid(seen);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_wins_over_hit", {16'd0, hit_cnt}, 32'd0);

    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
